// File: rtl/led_step_ctrl.sv
// Push-button sequencer: synchronises and debounces a raw button, then issues
// single-cycle advance pulses (one per press, periodic while held, pausable).
module led_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int AUTO_PERIOD     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_raw,
  input  logic       pause,
  output logic       advance,
  output logic [1:0] mode,
  output logic [7:0] step_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int AW = $clog2(AUTO_PERIOD);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESSED = 2'b01,
    AUTO    = 2'b10,
    PAUSED  = 2'b11
  } state_t;

  logic          s1, s2;
  logic          btn_db, btn_db_q;
  logic [DW-1:0] dcnt;
  logic          rise;

  state_t        state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [AW-1:0] timer, timer_nxt;
  logic          adv_nxt;

  // Input conditioning: two-flop synchroniser, then a counter that only
  // accepts a new level after DEBOUNCE_CYCLES consecutive differing samples.
  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      dcnt     <= '0;
    end else begin
      s1       <= button_raw;
      s2       <= s1;
      btn_db_q <= btn_db;
      if (s2 == btn_db) begin
        dcnt <= '0;
      end else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        btn_db <= s2;
        dcnt   <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  assign rise = btn_db & ~btn_db_q;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    timer_nxt = timer;
    adv_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESSED;
          adv_nxt   = 1'b1;
          hold_nxt  = '0;
        end
      end
      PRESSED: begin
        if (!btn_db) begin
          state_nxt = IDLE;
        end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          state_nxt = AUTO;
          timer_nxt = '0;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      AUTO: begin
        // Release beats pause, and a pulse due this cycle is dropped.
        if (!btn_db) begin
          state_nxt = IDLE;
        end else if (pause) begin
          state_nxt = PAUSED;
        end else if (timer == AW'(AUTO_PERIOD - 1)) begin
          adv_nxt   = 1'b1;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      PAUSED: begin
        if (!btn_db) begin
          state_nxt = IDLE;
        end else if (!pause) begin
          state_nxt = AUTO;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      timer      <= '0;
      advance    <= 1'b0;
      step_count <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      timer    <= timer_nxt;
      advance  <= adv_nxt;
      // Counts alongside the registered pulse so both change on the same edge.
      if (adv_nxt) step_count <= step_count + 8'd1;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_led_step_ctrl.sv
// Directed self-checking bench for led_step_ctrl at default parameters: reset,
// bounce rejection, short press, hold/auto-repeat, pause, counter wrap, mid-run reset.
module tb_led_step_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       button_raw;
  logic       pause;
  logic       advance;
  logic [1:0] mode;
  logic [7:0] step_count;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int s;

  localparam int HMAX = 4096;
  logic       hist_adv  [HMAX];
  logic [1:0] hist_mode [HMAX];
  logic [7:0] hist_cnt  [HMAX];

  always #5 clk = ~clk;

  led_step_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .button_raw(button_raw),
    .pause     (pause),
    .advance   (advance),
    .mode      (mode),
    .step_count(step_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are recorded 1 ns after the rising edge, indexed by edge count.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < HMAX) begin
      hist_adv[cyc]  = advance;
      hist_mode[cyc] = mode;
      hist_cnt[cyc]  = step_count;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  function automatic int pulses(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (hist_adv[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int max_mode(input int a, input int b);
    int m = 0;
    for (int i = a; i <= b; i++) if (int'(hist_mode[i]) > m) m = int'(hist_mode[i]);
    return m;
  endfunction

  initial begin
    int hi_len[5] = '{1, 2, 3, 1, 3};
    int back_to_back;

    // Reset held with button high; outputs clear immediately and stay clear.
    rst = 1'b0; button_raw = 1'b1; pause = 1'b0;
    #1;
    check("rst_t0_advance", advance, 0);
    check("rst_t0_mode", mode, 0);
    check("rst_t0_count", step_count, 0);
    run(2);
    check("rst_held_mode", mode, 0);
    check("rst_held_count", step_count, 0);
    button_raw = 1'b0;
    rst = 1'b1;
    run(8);

    // Bounce: every high burst is shorter than the debounce window.
    s = cyc;
    foreach (hi_len[i]) begin
      button_raw = 1'b1; run(hi_len[i]);
      button_raw = 1'b0; run(1);
    end
    run(12);
    check("bounce_pulses", pulses(s + 1, cyc), 0);
    check("bounce_mode", max_mode(s + 1, cyc), 0);
    check("bounce_count", step_count, 0);

    // Short press: pulse 7 cycles after the raw edge, back to IDLE 7 after release.
    s = cyc;
    button_raw = 1'b1; run(10);
    button_raw = 1'b0; run(20);
    check("short_pulses", pulses(s + 1, cyc), 1);
    check("short_pulse_at7", hist_adv[s + 7], 1);
    check("short_mode_at6", hist_mode[s + 6], 0);
    check("short_mode_at7", hist_mode[s + 7], 1);
    check("short_mode_at16", hist_mode[s + 16], 1);
    check("short_mode_at17", hist_mode[s + 17], 0);
    check("short_max_mode", max_mode(s + 1, cyc), 1);
    check("short_count", step_count, 1);

    // Hold 60 cycles: PRESSED at 7, AUTO at 23, pulses 7,31,39,47,55,63; IDLE at 67.
    s = cyc;
    button_raw = 1'b1; run(60);
    button_raw = 1'b0; run(20);
    check("hold_mode_at22", hist_mode[s + 22], 1);
    check("hold_mode_at23", hist_mode[s + 23], 2);
    check("hold_gap_pulses", pulses(s + 8, s + 30), 0);
    check("hold_first_auto", hist_adv[s + 31], 1);
    check("hold_last_auto", hist_adv[s + 63], 1);
    check("hold_pulses", pulses(s + 1, cyc), 6);
    check("hold_mode_at66", hist_mode[s + 66], 2);
    check("hold_mode_at67", hist_mode[s + 67], 0);
    check("hold_count", step_count, 7);

    // Pause three cycles into a period; the remaining five counts follow the resume.
    s = cyc;
    button_raw = 1'b1; run(34);
    pause = 1'b1; run(20);
    pause = 1'b0; run(16);
    pause = 1'b1; run(2);
    button_raw = 1'b0; run(20);
    check("pause_mode_at34", hist_mode[s + 34], 2);
    check("pause_mode_at35", hist_mode[s + 35], 3);
    check("pause_mode_at54", hist_mode[s + 54], 3);
    check("pause_mode_at55", hist_mode[s + 55], 2);
    check("pause_no_pulse", pulses(s + 32, s + 59), 0);
    check("pause_resume_pulse", hist_adv[s + 60], 1);
    check("pause_next_pulse", hist_adv[s + 68], 1);
    check("pause_release_at78", hist_mode[s + 78], 3);
    check("pause_release_at79", hist_mode[s + 79], 0);
    check("pause_pulses", pulses(s + 1, cyc), 4);
    check("pause_count", step_count, 11);
    pause = 1'b0;
    run(10);

    // Wrap: from 11, the 245th pulse of this press lands at offset 1975 and wraps to 0.
    s = cyc;
    button_raw = 1'b1; run(1998);
    check("wrap_count_255", hist_cnt[s + 1974], 255);
    check("wrap_pulse", hist_adv[s + 1975], 1);
    check("wrap_count_0", hist_cnt[s + 1975], 0);
    check("wrap_count_2", step_count, 2);
    check("wrap_mode_auto", mode, 2);

    // Asynchronous reset mid-cycle, one edge before a due pulse.
    #2;
    rst = 1'b0;
    #1;
    check("midrst_advance", advance, 0);
    check("midrst_mode", mode, 0);
    check("midrst_count", step_count, 0);
    button_raw = 1'b0;
    run(2);
    rst = 1'b1;
    s = cyc;
    run(30);
    check("postrst_pulses", pulses(s + 1, cyc), 0);
    check("postrst_mode", max_mode(s + 1, cyc), 0);

    s = cyc;
    button_raw = 1'b1; run(10);
    button_raw = 1'b0; run(20);
    check("repress_pulse_at7", hist_adv[s + 7], 1);
    check("repress_pulses", pulses(s + 1, cyc), 1);
    check("repress_count", step_count, 1);

    back_to_back = 0;
    for (int i = 2; i <= cyc; i++)
      if (hist_adv[i] === 1'b1 && hist_adv[i - 1] === 1'b1) back_to_back++;
    check("no_back_to_back", back_to_back, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
